// File: rtl/serial_sub16_pkg.sv
// rtl/serial_sub16_pkg.sv - shared state encodings and default width for serial_sub16
package serial_sub16_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor built from gate primitives
module full_subtractor (
    output logic diff,
    output logic borrow_out,
    input  logic a,
    input  logic b,
    input  logic borrow_in
);

    logic a_xor_b;
    logic a_xnor_b;
    logic borrow_gen;
    logic borrow_prop;

    my_xor u_xor_ab   (.y(a_xor_b),  .a(a),       .b(b));
    my_xor u_xor_diff (.y(diff),     .a(a_xor_b), .b(borrow_in));

    // (a ^ b) & b reduces to ~a & b, so the only inverter needed is on a ^ b
    my_and u_and_gen  (.y(borrow_gen), .a(a_xor_b), .b(b));

    assign a_xnor_b = ~a_xor_b;

    my_and u_and_prop (.y(borrow_prop), .a(a_xnor_b), .b(borrow_in));
    my_or  u_or_out   (.y(borrow_out),  .a(borrow_gen), .b(borrow_prop));

endmodule

// File: rtl/my_and.sv
// rtl/my_and.sv - two-input and gate primitive
module my_and (
    output logic y,
    input  logic a,
    input  logic b
);

    assign y = a & b;

endmodule

// File: rtl/my_or.sv
// rtl/my_or.sv - two-input or gate primitive
module my_or (
    output logic y,
    input  logic a,
    input  logic b
);

    assign y = a | b;

endmodule

// File: rtl/my_xor.sv
// rtl/my_xor.sv - two-input xor gate primitive
module my_xor (
    output logic y,
    input  logic a,
    input  logic b
);

    assign y = a ^ b;

endmodule

// File: rtl/serial_sub16.sv
// rtl/serial_sub16.sv - bit-serial subtractor, one bit per clock, LSB first
module serial_sub16
    import serial_sub16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // holds the lower WIDTH-1 result bits; the final bit joins them on the load into diff
    logic [WIDTH-2:0] diff_sh;
    logic [CNT_W-1:0] bit_cnt;
    logic             br;
    logic             bit_diff;
    logic             bit_borrow;
    logic             last_bit;

    assign last_bit = (bit_cnt == LAST_BIT);

    full_subtractor u_fs (
        .diff       (bit_diff),
        .borrow_out (bit_borrow),
        .a          (a_sh[0]),
        .b          (b_sh[0]),
        .borrow_in  (br)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            diff_sh    <= '0;
            bit_cnt    <= '0;
            br         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        br      <= borrow_in;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    br      <= bit_borrow;
                    diff_sh <= {bit_diff, diff_sh[WIDTH-2:1]};
                    if (last_bit) begin
                        diff       <= {bit_diff, diff_sh};
                        borrow_out <= bit_borrow;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub16.sv
// tb/tb_serial_sub16.sv - directed self-checking bench for serial_sub16
module tb_serial_sub16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        borrow_in;
    logic [15:0] diff;
    logic        borrow_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_sub16 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                          output int busy_cycles, output logic got_done);
        @(negedge clk);
        a = ta; b = tb_v; borrow_in = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge clk);
        end
        got_done = done;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (diff !== 16'h0) begin n_fail++; $display("FAIL reset_diff: got %h expected %h", diff, 16'h0); end
        n_checks++; if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL reset_borrow: got %b expected 0", borrow_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [15:0] va [4] = '{16'h0005, 16'h0003, 16'h0000, 16'h8000};
        logic [15:0] vb [4] = '{16'h0003, 16'h0005, 16'h0000, 16'h0001};
        logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] ed [4] = '{16'h0002, 16'hFFFE, 16'hFFFF, 16'h7FFF};
        logic        eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int   bc;
        logic gd;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], bc, gd);
            n_checks++; if (bc !== 16) begin n_fail++; $display("FAIL basic_busy_cycles[%0d]: got %0d expected 16", i, bc); end
            n_checks++; if (gd !== 1'b1) begin n_fail++; $display("FAIL basic_done[%0d]: got %b expected 1", i, gd); end
            n_checks++; if (diff !== ed[i]) begin n_fail++; $display("FAIL basic_diff[%0d]: got %h expected %h", i, diff, ed[i]); end
            n_checks++; if (borrow_out !== eb[i]) begin n_fail++; $display("FAIL basic_borrow[%0d]: got %b expected %b", i, borrow_out, eb[i]); end
            @(negedge clk);
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width[%0d]: got %b expected 0", i, done); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after[%0d]: got %b expected 0", i, busy); end
        end
    endtask

    task automatic test_ignore_start;
        int pulses = 0;
        int done_k = -1;
        @(negedge clk);
        a = 16'h1234; b = 16'h0234; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                pulses++;
                done_k = k;
                n_checks++; if (diff !== 16'h1000) begin n_fail++; $display("FAIL ignore_diff: got %h expected %h", diff, 16'h1000); end
                n_checks++; if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL ignore_borrow: got %b expected 0", borrow_out); end
            end
            if (k == 8) begin
                n_checks++; if (diff !== 16'h7FFF) begin n_fail++; $display("FAIL hold_diff_in_shift: got %h expected %h", diff, 16'h7FFF); end
            end
            if (k == 4) begin
                start = 1'b1; a = 16'hFFFF; b = 16'h0001; borrow_in = 1'b1;
            end
            if (k == 6) start = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
        n_checks++; if (done_k !== 16) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 16", done_k); end
    endtask

    task automatic test_reset_mid;
        int   pulses = 0;
        int   bc;
        logic gd;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (diff !== 16'h0) begin n_fail++; $display("FAIL midrst_diff: got %h expected %h", diff, 16'h0); end
        n_checks++; if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL midrst_borrow: got %b expected 0", borrow_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", pulses); end
        run_op(16'd10, 16'd4, 1'b0, bc, gd);
        n_checks++; if (gd !== 1'b1) begin n_fail++; $display("FAIL midrst_fresh_done: got %b expected 1", gd); end
        n_checks++; if (diff !== 16'h0006) begin n_fail++; $display("FAIL midrst_fresh_diff: got %h expected %h", diff, 16'h0006); end
    endtask

    task automatic test_back_to_back;
        int times [8];
        int n = 0;
        @(negedge clk);
        a = 16'h0007; b = 16'h0002; borrow_in = 1'b0; start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done && n < 8) begin
                times[n] = k;
                n++;
            end
        end
        start = 1'b0;
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", n); end
        if (n >= 3) begin
            n_checks++; if (times[1] - times[0] !== 18) begin n_fail++; $display("FAIL b2b_gap1: got %0d expected 18", times[1] - times[0]); end
            n_checks++; if (times[2] - times[1] !== 18) begin n_fail++; $display("FAIL b2b_gap2: got %0d expected 18", times[2] - times[1]); end
        end
        n_checks++; if (diff !== 16'h0005) begin n_fail++; $display("FAIL b2b_diff: got %h expected %h", diff, 16'h0005); end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_sub16.md
SERIAL_SUB16 -- requirements
Module: serial_sub16

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin a subtraction, sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  minuend, captured when start is accepted.
REQ-006 b  input  WIDTH  subtrahend, captured when start is accepted.
REQ-007 borrow_in  input  1  initial borrow, captured when start is accepted.
REQ-008 diff  output  WIDTH  registered result, a - b - borrow_in modulo 2^WIDTH.
REQ-009 borrow_out  output  1  registered final borrow; 1 when a < b + borrow_in, unsigned.
REQ-010 busy  output  1  high while a subtraction is in progress.
REQ-011 done  output  1  one-cycle pulse marking that diff and borrow_out are valid.

Function
REQ-012 The block SHALL implement a state machine with exactly the states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1 at edge E0, the block SHALL capture a, b and borrow_in, clear the bit counter, and enter SHIFT.
REQ-014 In SHIFT, each edge SHALL process one bit, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-015 Result bits SHALL shift into an internal diff register from the MSB end, so that after WIDTH shifts bit 0 is in position 0.
REQ-016 At edge E16 (after the 16th processed bit), the block SHALL enter DONE, load diff and borrow_out, and drive done=1.
REQ-017 DONE SHALL last exactly one cycle, then return unconditionally to IDLE at E17.
REQ-018 busy SHALL be 1 exactly while the state is SHIFT, for 16 cycles per operation.
REQ-019 done SHALL be 0 in every state except DONE.
REQ-020 Latency SHALL be fixed: done is high in the cycle following E16, independent of the operand values.
REQ-021 start in SHIFT or DONE SHALL be ignored, with no effect on operands, counter or result.
REQ-022 Changes on a, b or borrow_in after E0 SHALL NOT affect the current result.
REQ-023 diff and borrow_out SHALL hold the last completed result until the next DONE; they SHALL NOT change during SHIFT.
REQ-024 The bit counter SHALL count from 0 to WIDTH-1 and SHALL NOT wrap within an operation.

Reset
REQ-025 Assertion of rst SHALL immediately force state=IDLE, diff=0, borrow_out=0, busy=0, done=0, the counter and internal borrow to 0, and the operand registers to 0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-027 The first start accepted after reset deassertion SHALL behave per REQ-013.

Structure
REQ-028 The state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the WIDTH default SHALL reside in the shared global include file, not be local to the module.
REQ-029 The one-bit subtraction of REQ-014 SHALL be a single sub-module full_subtractor(diff, borrow_out, a, b, borrow_in), built from my_xor, my_and and my_or, plus one inverter.
REQ-030 Only one full_subtractor instance SHALL exist; the datapath SHALL be bit-serial.

Verification
REQ-031 a=5, b=3, borrow_in=0, start pulse -> busy for 16 cycles, then done; diff=0x0002, borrow_out=0.
REQ-032 a=3, b=5, borrow_in=0 -> diff=0xFFFE, borrow_out=1.
REQ-033 a=0, b=0, borrow_in=1 -> diff=0xFFFF, borrow_out=1; a=0x8000, b=0x0001, borrow_in=0 -> diff=0x7FFF, borrow_out=0.
REQ-034 a=0x1234, b=0x0234, start; start re-pulsed with a=0xFFFF at cycle 5 and operands changed -> single done at the fixed latency; diff=0x1000, borrow_out=0.
REQ-035 rst asserted at cycle 8 of an operation -> outputs 0 immediately, no done; a fresh start with a=10, b=4 -> diff=0x0006.
REQ-036 Back-to-back: start held high continuously -> consecutive operations, with done pulses exactly 18 cycles apart.
